pcg_stream_gen: RTL and testbench

//  Parametrised multi-channel PCG (LCG state + XSH-RR output) noise generator for the demoscene VGA path.
//  It runs NUM_CH independent streams with a common seed and per-channel increments, through a 2-stage output pipeline.

---
 rtl/pcg_stream_gen.sv | 127 ++++++++++++
 tb/tb_pcg_stream_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pcg_stream_gen.sv
// pcg_stream_gen: NUM_CH parallel PCG generators (LCG state advance with an
// XSH-RR output permutation) feeding a two-stage output pipeline. The output
// uses a valid/ready handshake. Generation can be paused with run, and every
// channel can be reloaded at runtime with seed_load.
module pcg_stream_gen #(
    parameter int                 STATE_W = 16,
    parameter int                 OUT_W   = 8,
    parameter int                 NUM_CH  = 1,
    parameter logic [STATE_W-1:0] MULT    = 'h5851,
    parameter logic [STATE_W-1:0] INC     = 'h1405,
    parameter logic [STATE_W-1:0] SEED    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      seed_load,
    input  logic [STATE_W-1:0]        seed_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*OUT_W-1:0]   out_data
);

    // XSH-RR permutation geometry: R rotate bits, XS xorshift and SH final shift.
    localparam int R  = $clog2(OUT_W);
    localparam int XS = (OUT_W + R) / 2;
    localparam int SH = STATE_W - OUT_W - R;

    // OUT_W is a power of two, so an R-bit index sum wraps naturally modulo OUT_W.
    function automatic logic [OUT_W-1:0] rotr(input logic [OUT_W-1:0] x,
                                              input logic [R-1:0]     r);
        for (int b = 0; b < OUT_W; b++) begin
            rotr[b] = x[R'(b) + r];
        end
    endfunction

    logic adv;
    logic v1_reg, v1_next;
    logic out_valid_reg, out_valid_next;

    // The whole pipeline moves together. It freezes only while a valid word
    // waits for the consumer.
    assign adv       = !out_valid_reg || out_ready;
    assign out_valid = out_valid_reg;

    // Shared valid bits. A reseed kills both stages even during a stall.
    always_comb begin
        v1_next        = v1_reg;
        out_valid_next = out_valid_reg;
        if (seed_load) begin
            v1_next        = 1'b0;
            out_valid_next = 1'b0;
        end else if (adv) begin
            v1_next        = run;
            out_valid_next = v1_reg;
        end
    end

    // Valid-bit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            v1_reg        <= v1_next;
            out_valid_reg <= out_valid_next;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
        // Odd increments that differ per channel keep the streams distinct
        // while each stream keeps the full period.
        localparam logic [STATE_W-1:0] CH_INC = INC + STATE_W'(2 * gi);

        logic [STATE_W-1:0] state_reg, state_next;
        logic [STATE_W-1:0] mix;
        logic [OUT_W-1:0]   xs;
        logic [R-1:0]       rot;
        logic [OUT_W-1:0]   s1_xs_reg, s1_xs_next;
        logic [R-1:0]       s1_rot_reg, s1_rot_next;
        logic [OUT_W-1:0]   out_word_reg, out_word_next;
        logic               mix_unused;

        // The permutation uses the state before it advances. Stage 1 keeps the
        // xorshifted word and the rotate amount. The rotate itself happens in
        // stage 2.
        assign mix        = (state_reg >> XS) ^ state_reg;
        assign xs         = mix[SH +: OUT_W];
        assign rot        = state_reg[STATE_W-1 -: R];
        assign mix_unused = ^{mix[STATE_W-1 -: R], mix[SH-1:0]};

        // Next-state for the LCG, stage 1 and the output word of this channel.
        always_comb begin
            state_next    = state_reg;
            s1_xs_next    = s1_xs_reg;
            s1_rot_next   = s1_rot_reg;
            out_word_next = out_word_reg;
            if (seed_load) begin
                state_next = seed_data;
            end else if (adv) begin
                out_word_next = rotr(s1_xs_reg, s1_rot_reg);
                if (run) begin
                    state_next  = state_reg * MULT + CH_INC;
                    s1_xs_next  = xs;
                    s1_rot_next = rot;
                end
            end
        end

        // Per-channel registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_reg    <= SEED;
                s1_xs_reg    <= '0;
                s1_rot_reg   <= '0;
                out_word_reg <= '0;
            end else begin
                state_reg    <= state_next;
                s1_xs_reg    <= s1_xs_next;
                s1_rot_reg   <= s1_rot_next;
                out_word_reg <= out_word_next;
            end
        end

        assign out_data[gi*OUT_W +: OUT_W] = out_word_reg;
    end

endmodule

// File: tb/tb_pcg_stream_gen.sv
// tb_pcg_stream_gen: drives a default 16/8/1 instance and a 32/16/4 instance
// with shared control. Each accepted sample is compared against an arithmetic
// PCG stream model. The model restarts on rst or seed_load.
module tb_pcg_stream_gen;

    logic        clk = 1'b0;
    logic        rst, run, seed_load, out_ready;
    logic [15:0] seed_data;
    logic [31:0] seed_data_b;
    logic        a_valid, b_valid;
    logic [7:0]  a_data;
    logic [63:0] b_data;

    int n_cmp = 0;
    int n_bad = 0;
    bit verbose = 1'b1;

    longint unsigned a_st, b_st[4];
    int              a_cnt, b_cnt;
    bit              b_from_rst;

    bit run_pat[6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit valid_pat[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;
    assign seed_data_b = {16'h0000, seed_data};

    pcg_stream_gen dut_a (
        .clk(clk), .rst(rst), .run(run), .seed_load(seed_load),
        .seed_data(seed_data), .out_valid(a_valid), .out_ready(out_ready),
        .out_data(a_data)
    );

    pcg_stream_gen #(.STATE_W(32), .OUT_W(16), .NUM_CH(4)) dut_b (
        .clk(clk), .rst(rst), .run(run), .seed_load(seed_load),
        .seed_data(seed_data_b), .out_valid(b_valid), .out_ready(out_ready),
        .out_data(b_data)
    );

    // PCG XSH-RR output of state s for a state width of sw bits.
    function automatic longint unsigned pcg_out(longint unsigned s, int sw);
        int ow = sw / 2;
        int r = $clog2(ow);
        int xsh = (ow + r) / 2;
        int sh = sw - ow - r;
        longint unsigned omask = (64'd1 << ow) - 1;
        longint unsigned x = (((s >> xsh) ^ s) >> sh) & omask;
        int rot = int'(s >> (sw - r));
        return ((x >> rot) | (x << (ow - rot))) & omask;
    endfunction

    function automatic longint unsigned lcg_next(longint unsigned s, longint unsigned inc, int sw);
        longint unsigned smask = (64'd1 << sw) - 1;
        return (s * 64'h5851 + inc) & smask;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the coming edge. Inputs and outputs are stable at the negedge.
    task automatic monitor();
        if (rst) begin
            a_st = 0; a_cnt = 0; b_cnt = 0; b_from_rst = 1'b1;
            for (int c = 0; c < 4; c++) b_st[c] = 0;
        end else begin
            if (a_valid && out_ready) begin
                if (verbose) $display("A accept #%0d data=%02h", a_cnt, a_data);
                check("a_stream", {56'h0, a_data}, pcg_out(a_st, 16));
                if (a_cnt == 65536) check("a_period_wrap0", {56'h0, a_data}, pcg_out(0, 16));
                if (a_cnt == 65537) check("a_period_wrap1", {56'h0, a_data}, pcg_out(64'h1405, 16));
                a_st = lcg_next(a_st, 64'h1405, 16);
                a_cnt++;
            end
            if (b_valid && out_ready) begin
                if (verbose) $display("B accept #%0d data=%016h", b_cnt, b_data);
                for (int c = 0; c < 4; c++) begin
                    check($sformatf("b_stream_ch%0d", c), {48'h0, b_data[c*16 +: 16]}, pcg_out(b_st[c], 32));
                    b_st[c] = lcg_next(b_st[c], 64'h1405 + 64'(2 * c), 32);
                end
                if (b_from_rst && b_cnt == 2)
                    check("b_ch0_ne_ch1", {63'h0, b_data[15:0] != b_data[31:16]}, 64'h1);
                b_cnt++;
            end
            if (seed_load) begin
                a_st = seed_data; a_cnt = 0; b_cnt = 0; b_from_rst = 1'b0;
                for (int c = 0; c < 4; c++) b_st[c] = seed_data;
            end
        end
    endtask

    // Account for the coming edge, then return at the next negedge.
    task automatic tick();
        monitor();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #(10 * 120000);
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; seed_load = 1'b0; seed_data = '0; out_ready = 1'b0;
        @(negedge clk);
        tick(); tick();
        check("rst_a_valid", {63'h0, a_valid}, 64'h0);
        check("rst_a_data",  {56'h0, a_data}, 64'h0);
        check("rst_b_valid", {63'h0, b_valid}, 64'h0);
        check("rst_b_data",  b_data, 64'h0);

        // First samples: state 0 then state 16'h1405, two edges of latency.
        rst = 1'b0; run = 1'b1; out_ready = 1'b1;
        tick();
        check("t1_lat_valid", {63'h0, a_valid}, 64'h0);
        tick();
        check("t1_first_valid", {63'h0, a_valid}, 64'h1);
        check("t1_first_data",  {56'h0, a_data}, 64'h00);
        tick();
        check("t1_second_data", {56'h0, a_data}, 64'hA5);
        repeat (6) tick();

        // Backpressure: the output word freezes on the pending sample.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_stall_valid", {63'h0, a_valid}, 64'h1);
            check("t2_stall_data",  {56'h0, a_data}, pcg_out(a_st, 16));
        end
        out_ready = 1'b1;
        repeat (5) tick();

        // Reseed while a valid word is stalled.
        out_ready = 1'b0;
        tick();
        check("t3_pre_valid", {63'h0, a_valid}, 64'h1);
        seed_load = 1'b1; seed_data = 16'h1405;
        tick();
        seed_load = 1'b0;
        check("t3_drop_valid", {63'h0, a_valid}, 64'h0);
        out_ready = 1'b1;
        tick();
        check("t3_gap_valid", {63'h0, a_valid}, 64'h0);
        tick();
        check("t3_first_valid", {63'h0, a_valid}, 64'h1);
        check("t3_first_data",  {56'h0, a_data}, 64'hA5);
        repeat (3) tick();

        // Pause for two cycles. The output shows a two-cycle hole two edges later.
        for (int k = 0; k < 6; k++) begin
            run = run_pat[k];
            tick();
            check($sformatf("t4_valid_%0d", k), {63'h0, a_valid}, {63'h0, valid_pat[k]});
        end

        // Random control mix with occasional reseeds.
        for (int k = 0; k < 400; k++) begin
            run       = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            seed_load = ($urandom_range(0, 49) == 0);
            seed_data = 16'($urandom);
            tick();
        end
        seed_load = 1'b0;

        // Full period at defaults, then a reset in mid-stream.
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b1; out_ready = 1'b1; verbose = 1'b0;
        repeat (65545) tick();
        check("t6_samples_seen", {63'h0, a_cnt > 65537}, 64'h1);
        verbose = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", {63'h0, a_valid}, 64'h0);
        tick();
        check("t6_restart_gap", {63'h0, a_valid}, 64'h0);
        tick();
        check("t6_restart_valid", {63'h0, a_valid}, 64'h1);
        check("t6_restart_data",  {56'h0, a_data}, 64'h00);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
